// File: rtl/psum_accum_mem.sv
// psum_accum_mem: partial-sum memory with write, read, saturating in-place
// accumulate (two-stage read-modify-write with forwarding) and a bulk clear
// sweep. Reads leave through a one-entry valid/ready output register with
// optional per-lane ReLU.
module psum_accum_mem #(
   parameter int psum_bw    = 16,
   parameter int col        = 8,
   parameter int addr_width = 11,
   parameter int depth      = 1 << addr_width
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [1:0]                in_mode,
   input  logic [addr_width-1:0]     in_addr,
   input  logic [psum_bw*col-1:0]    in_data,
   input  logic                      relu_en,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [psum_bw*col-1:0]    out_data,
   output logic                      busy
);

   localparam int dw = psum_bw * col;
   localparam logic [1:0] MODE_WR  = 2'b00;
   localparam logic [1:0] MODE_ACC = 2'b01;
   localparam logic [1:0] MODE_RD  = 2'b10;
   localparam logic [1:0] MODE_CLR = 2'b11;
   localparam logic [addr_width-1:0] LAST_ADDR = addr_width'(depth - 1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   // Saturating signed add of one lane, computed one bit wider than a lane.
   function automatic logic [psum_bw-1:0] sat_lane(
      input logic [psum_bw-1:0] a,
      input logic [psum_bw-1:0] b
   );
      logic [psum_bw:0] s;
      s = {a[psum_bw-1], a} + {b[psum_bw-1], b};
      if (s[psum_bw] != s[psum_bw-1]) begin
         if (s[psum_bw]) begin
            sat_lane = {1'b1, {(psum_bw-1){1'b0}}};
         end else begin
            sat_lane = {1'b0, {(psum_bw-1){1'b1}}};
         end
      end else begin
         sat_lane = s[psum_bw-1:0];
      end
   endfunction

   // Lane-wise saturating add of two entries.
   function automatic logic [dw-1:0] sat_vec(
      input logic [dw-1:0] a,
      input logic [dw-1:0] b
   );
      logic [dw-1:0] r;
      r = {dw{1'b0}};
      for (int k = 0; k < col; k++) begin
         r[k*psum_bw +: psum_bw] = sat_lane(a[k*psum_bw +: psum_bw],
                                            b[k*psum_bw +: psum_bw]);
      end
      return r;
   endfunction

   // Lane-wise ReLU: negative lanes become zero.
   function automatic logic [dw-1:0] relu_vec(input logic [dw-1:0] a);
      logic [dw-1:0] r;
      r = a;
      for (int k = 0; k < col; k++) begin
         if (a[k*psum_bw + psum_bw - 1]) begin
            r[k*psum_bw +: psum_bw] = {psum_bw{1'b0}};
         end else begin
            r[k*psum_bw +: psum_bw] = a[k*psum_bw +: psum_bw];
         end
      end
      return r;
   endfunction

   logic [dw-1:0] mem_q [0:depth-1];

   state_t                  state_q, state_d;
   logic                    busy_q, busy_d;
   logic [addr_width-1:0]   clr_addr_q, clr_addr_d;
   logic                    s2_valid_q, s2_valid_d;
   logic [addr_width-1:0]   s2_addr_q, s2_addr_d;
   logic [dw-1:0]           s2_add_q, s2_add_d;
   logic [dw-1:0]           s2_old_q, s2_old_d;
   logic                    out_valid_q, out_valid_d;
   logic [dw-1:0]           out_data_q, out_data_d;

   logic                    in_ready_s;
   logic                    accept_s;
   logic                    wr_acc_s, acc_acc_s, rd_acc_s, clr_acc_s;
   logic [dw-1:0]           s2_sum_s;
   logic [dw-1:0]           entry_s;

   assign in_ready  = in_ready_s;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign busy      = busy_q;

   // Pending stage-2 result, also the forwarding source.
   assign s2_sum_s = sat_vec(s2_old_q, s2_add_q);

   // Request acceptance: blocked in reset, during clear, or when a read would overflow the output register.
   always_comb begin
      in_ready_s = 1'b1;
      if (reset) begin
         in_ready_s = 1'b0;
      end else if (state_q == ST_CLEAR) begin
         in_ready_s = 1'b0;
      end else if (in_valid && (in_mode == MODE_RD) && out_valid_q && !out_ready) begin
         in_ready_s = 1'b0;
      end else begin
         in_ready_s = 1'b1;
      end
   end

   // Decode the accepted request into one strobe per mode.
   always_comb begin
      accept_s  = in_valid && in_ready_s;
      wr_acc_s  = 1'b0;
      acc_acc_s = 1'b0;
      rd_acc_s  = 1'b0;
      clr_acc_s = 1'b0;
      case (in_mode)
         MODE_WR:  wr_acc_s  = accept_s;
         MODE_ACC: acc_acc_s = accept_s;
         MODE_RD:  rd_acc_s  = accept_s;
         MODE_CLR: clr_acc_s = accept_s;
         default: begin
            wr_acc_s  = 1'b0;
            acc_acc_s = 1'b0;
            rd_acc_s  = 1'b0;
            clr_acc_s = 1'b0;
         end
      endcase
   end

   // Current value of the addressed entry, taking a pending same-address sum over stale memory.
   always_comb begin
      entry_s = mem_q[in_addr];
      if (s2_valid_q && (s2_addr_q == in_addr)) begin
         entry_s = s2_sum_s;
      end else begin
         entry_s = mem_q[in_addr];
      end
   end

   // Next state for the FSM, accumulate pipeline and output register.
   always_comb begin
      state_d     = state_q;
      clr_addr_d  = clr_addr_q;
      s2_valid_d  = acc_acc_s;
      s2_addr_d   = s2_addr_q;
      s2_add_d    = s2_add_q;
      s2_old_d    = s2_old_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;

      case (state_q)
         ST_IDLE: begin
            if (clr_acc_s) begin
               state_d    = ST_CLEAR;
               clr_addr_d = {addr_width{1'b0}};
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CLEAR: begin
            if (clr_addr_q == LAST_ADDR) begin
               state_d    = ST_IDLE;
               clr_addr_d = {addr_width{1'b0}};
            end else begin
               state_d    = ST_CLEAR;
               clr_addr_d = clr_addr_q + {{(addr_width-1){1'b0}}, 1'b1};
            end
         end
         default: begin
            state_d    = ST_IDLE;
            clr_addr_d = {addr_width{1'b0}};
         end
      endcase
      busy_d = (state_d == ST_CLEAR);

      if (acc_acc_s) begin
         s2_addr_d = in_addr;
         s2_add_d  = in_data;
         s2_old_d  = entry_s;
      end else begin
         s2_addr_d = s2_addr_q;
         s2_add_d  = s2_add_q;
         s2_old_d  = s2_old_q;
      end

      if (rd_acc_s) begin
         out_valid_d = 1'b1;
         if (relu_en) begin
            out_data_d = relu_vec(entry_s);
         end else begin
            out_data_d = entry_s;
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
         out_data_d  = out_data_q;
      end else begin
         out_valid_d = out_valid_q;
         out_data_d  = out_data_q;
      end
   end

   // Control and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         busy_q      <= 1'b0;
         clr_addr_q  <= {addr_width{1'b0}};
         s2_valid_q  <= 1'b0;
         s2_addr_q   <= {addr_width{1'b0}};
         s2_add_q    <= {dw{1'b0}};
         s2_old_q    <= {dw{1'b0}};
         out_valid_q <= 1'b0;
         out_data_q  <= {dw{1'b0}};
      end else begin
         state_q     <= state_d;
         busy_q      <= busy_d;
         clr_addr_q  <= clr_addr_d;
         s2_valid_q  <= s2_valid_d;
         s2_addr_q   <= s2_addr_d;
         s2_add_q    <= s2_add_d;
         s2_old_q    <= s2_old_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   // Memory writes: commit, then request write (so a colliding write wins), then clear sweep; nothing lands in reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (s2_valid_q) begin
            mem_q[s2_addr_q] <= s2_sum_s;
         end
         if (wr_acc_s) begin
            mem_q[in_addr] <= in_data;
         end
         if (state_q == ST_CLEAR) begin
            mem_q[clr_addr_q] <= {dw{1'b0}};
         end
      end
   end

endmodule

// File: tb/tb_psum_accum_mem.sv
// Self-checking bench for psum_accum_mem (16-entry configuration) with a
// lane-arithmetic reference model.
module tb_psum_accum_mem;

   localparam int PBW = 16;
   localparam int COL = 8;
   localparam int AW  = 4;
   localparam int DEP = 16;
   localparam int DW  = PBW * COL;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [1:0]    in_mode;
   logic [AW-1:0] in_addr;
   logic [DW-1:0] in_data;
   logic          relu_en;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic          busy;

   int n_checks = 0;
   int n_fail   = 0;
   logic [DW-1:0] model_mem [DEP];

   psum_accum_mem #(.psum_bw(PBW), .col(COL), .addr_width(AW), .depth(DEP)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_mode(in_mode), .in_addr(in_addr), .in_data(in_data), .relu_en(relu_en),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] rep(input logic [PBW-1:0] v);
      return {COL{v}};
   endfunction

   function automatic logic [DW-1:0] m_sat_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
      logic [DW-1:0] r;
      int x, y, s;
      r = '0;
      for (int k = 0; k < COL; k++) begin
         x = int'($signed(a[k*PBW +: PBW]));
         y = int'($signed(b[k*PBW +: PBW]));
         s = x + y;
         if (s > 32767) s = 32767;
         if (s < -32768) s = -32768;
         r[k*PBW +: PBW] = 16'(s);
      end
      return r;
   endfunction

   function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a, input logic r);
      logic [DW-1:0] v;
      v = model_mem[a];
      if (r) begin
         for (int k = 0; k < COL; k++) begin
            if (int'($signed(v[k*PBW +: PBW])) < 0) v[k*PBW +: PBW] = '0;
         end
      end
      return v;
   endfunction

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Offer one request, wait (bounded) for acceptance, update the model at the accept edge.
   task automatic req(input logic [1:0] m, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic r);
      int waited;
      waited = 0;
      in_valid = 1'b1; in_mode = m; in_addr = a; in_data = d; relu_en = r;
      #1;
      while (in_ready !== 1'b1 && waited < 50) begin
         @(posedge clk); #1;
         waited++;
      end
      check("req_accept", {{(DW-1){1'b0}}, in_ready}, {{(DW-1){1'b0}}, 1'b1});
      case (m)
         2'b00: model_mem[a] = d;
         2'b01: model_mem[a] = m_sat_add(model_mem[a], d);
         2'b11: for (int i = 0; i < DEP; i++) model_mem[i] = '0;
         default: ;
      endcase
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic do_read(input string tag, input logic [AW-1:0] a, input logic r, input logic [DW-1:0] exp);
      out_ready = 1'b1;
      req(2'b10, a, '0, r);
      check({tag, "_valid"}, {{(DW-1){1'b0}}, out_valid}, {{(DW-1){1'b0}}, 1'b1});
      check(tag, out_data, exp);
   endtask

   task automatic fill(input logic [PBW-1:0] v);
      for (int i = 0; i < DEP; i++) req(2'b00, AW'(i), rep(v), 1'b0);
   endtask

   initial begin
      logic [DW-1:0] held, exp, d;
      logic [1:0] m;
      logic [AW-1:0] a;
      logic r;
      int cnt;

      // Reset
      reset = 1'b1; in_valid = 1'b1; in_mode = 2'b00; in_addr = '0; in_data = '0;
      relu_en = 1'b0; out_ready = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("rst_in_ready", {{(DW-1){1'b0}}, in_ready}, '0);
      check("rst_out_valid", {{(DW-1){1'b0}}, out_valid}, '0);
      check("rst_out_data", out_data, '0);
      check("rst_busy", {{(DW-1){1'b0}}, busy}, '0);
      reset = 1'b0; in_valid = 1'b0; #1;
      check("post_rst_in_ready", {{(DW-1){1'b0}}, in_ready}, {{(DW-1){1'b0}}, 1'b1});

      // Initialise memory with random data
      for (int i = 0; i < DEP; i++) req(2'b00, AW'(i), {$urandom, $urandom, $urandom, $urandom}, 1'b0);

      // Write/read with backpressure
      req(2'b00, 4'd5, rep(16'h0010), 1'b0);
      out_ready = 1'b0;
      req(2'b10, 4'd5, '0, 1'b0);
      check("bp_valid", {{(DW-1){1'b0}}, out_valid}, {{(DW-1){1'b0}}, 1'b1});
      check("bp_data", out_data, rep(16'h0010));
      held = out_data;
      in_valid = 1'b1; in_mode = 2'b10; in_addr = 4'd3; #1;
      check("bp_in_ready_low", {{(DW-1){1'b0}}, in_ready}, '0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("bp_hold_data", out_data, rep(16'h0010));
      check("bp_hold_valid", {{(DW-1){1'b0}}, out_valid}, {{(DW-1){1'b0}}, 1'b1});
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_drain", {{(DW-1){1'b0}}, out_valid}, '0);

      // Forwarding
      req(2'b00, 4'd7, '0, 1'b0);
      req(2'b01, 4'd7, rep(16'h0003), 1'b0);
      req(2'b01, 4'd7, rep(16'h0003), 1'b0);
      req(2'b01, 4'd7, rep(16'h0003), 1'b0);
      do_read("fwd_acc3", 4'd7, 1'b0, rep(16'h0009));
      req(2'b01, 4'd7, rep(16'h0003), 1'b0);
      req(2'b00, 4'd7, rep(16'h0001), 1'b0);
      do_read("fwd_write_wins", 4'd7, 1'b0, rep(16'h0001));

      // Saturation
      req(2'b00, 4'd1, rep(16'h7FF0), 1'b0);
      req(2'b01, 4'd1, rep(16'h0020), 1'b0);
      do_read("sat_pos", 4'd1, 1'b0, rep(16'h7FFF));
      req(2'b00, 4'd2, rep(16'h8010), 1'b0);
      req(2'b01, 4'd2, rep(16'hFFE0), 1'b0);
      do_read("sat_neg", 4'd2, 1'b0, rep(16'h8000));
      req(2'b00, 4'd3, rep(16'h0005), 1'b0);
      req(2'b01, 4'd3, rep(16'hFFFD), 1'b0);
      do_read("sat_none", 4'd3, 1'b0, rep(16'h0002));

      // ReLU
      d = '0; d[15:0] = 16'hFFFB; d[31:16] = 16'h0005;
      req(2'b00, 4'd9, d, 1'b0);
      exp = '0; exp[31:16] = 16'h0005;
      do_read("relu_on", 4'd9, 1'b1, exp);
      do_read("relu_off", 4'd9, 1'b0, d);

      // Randomised back-to-back traffic over a few hot addresses
      out_ready = 1'b1;
      for (int i = 0; i < 120; i++) begin
         m = 2'($urandom_range(0, 2));
         a = AW'($urandom_range(0, 3));
         r = 1'($urandom_range(0, 1));
         d = {$urandom, $urandom, $urandom, $urandom};
         exp = m_read(a, r);
         req(m, a, d, r);
         if (m == 2'b10) begin
            check("rand_valid", {{(DW-1){1'b0}}, out_valid}, {{(DW-1){1'b0}}, 1'b1});
            check("rand_data", out_data, exp);
         end
      end
      for (int i = 0; i < 4; i++) do_read("rand_final", AW'(i), 1'b0, m_read(AW'(i), 1'b0));

      // Clear sweep
      fill(16'h1234);
      req(2'b11, '0, '0, 1'b0);
      cnt = 0;
      in_valid = 1'b1; in_mode = 2'b00; in_addr = '0; in_data = '0;
      while (busy === 1'b1 && cnt < 40) begin
         cnt++;
         if (cnt == 2) check("clr_in_ready_low", {{(DW-1){1'b0}}, in_ready}, '0);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      check("clr_busy_cycles", DW'(cnt), DW'(16));
      check("clr_in_ready_back", {{(DW-1){1'b0}}, in_ready}, {{(DW-1){1'b0}}, 1'b1});
      for (int i = 0; i < DEP; i++) do_read("clr_zero", AW'(i), 1'b0, '0);

      // Reset during the clear sweep
      fill(16'h1234);
      req(2'b11, '0, '0, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      check("clr_rst_busy", {{(DW-1){1'b0}}, busy}, '0);
      reset = 1'b0;
      for (int i = 0; i < DEP; i++) model_mem[i] = rep(16'h1234);
      for (int i = 0; i < 3; i++) model_mem[i] = '0;
      for (int i = 0; i < 3; i++) do_read("clr_rst_swept", AW'(i), 1'b0, m_read(AW'(i), 1'b0));
      do_read("clr_rst_untouched", 4'd15, 1'b0, rep(16'h1234));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/psum_accum_mem.md
# psum_accum_mem

Parametrised output partial-sum memory that replaces the plain write/read pmem array beside the corelet. Each entry holds a `col`-lane vector of signed psums. It supports four modes: write, read, in-place saturating accumulate (read-modify-write with hazard forwarding), and a bulk clear sweep. Read data leaves through a one-entry valid/ready output register with optional ReLU, so partial sums from successive tiles are summed in memory rather than in the testbench.

## Interface
- `psum_bw`, 16: signed width of one lane.
- `col`, 8: number of lanes per entry.
- `addr_width`, 11: address bits.
- `depth`, 1<<addr_width: number of entries. Must be ≤ 2^addr_width.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: a request is present.
- `in_ready` out 1: the request is accepted on an edge where `in_valid && in_ready`.
- `in_mode` in 2: 00 write, 01 accumulate, 10 read, 11 clear-all.
- `in_addr` in addr_width: entry address. Ignored for clear.
- `in_data` in psum_bw*col: write or addend data. Lane k is at bits [psum_bw*(k+1)-1 : psum_bw*k].
- `relu_en` in 1: sampled with a read request. Clamps negative lanes to 0 on output.
- `out_valid` out 1: `out_data` holds a read result.
- `out_ready` in 1: consumer accepts `out_data` on an edge where `out_valid && out_ready`.
- `out_data` out psum_bw*col: registered read result.
- `busy` out 1: high while the clear sweep runs.

## Operation
- The FSM has two states, IDLE and CLEAR.
- `in_ready` is 0 when `reset` is high, when the state is CLEAR, or when a read is offered while the output register is full and `out_ready` is 0. Otherwise `in_ready` is 1.
- **Write:** `mem[addr] <= in_data` at the accept edge.
- **Read:** at the accept edge, `out_data` is loaded with the entry, with per-lane ReLU applied if `relu_en` is set, and `out_valid` is set.
  - `out_valid` clears on an edge where `out_ready` is high and no new read is accepted.
  - A new read accepted on the same edge that the old result is consumed reloads the register, and `out_valid` stays 1.
  - `out_data` holds its value whenever `out_valid && !out_ready`.
- **Accumulate** is a two-stage pipeline:
  - Stage 1 (accept edge): latch `addr`, `in_data`, and the old entry.
  - Stage 2 (next edge): write `mem[addr] <=` the per-lane saturating signed sum `old + addend`.
  - Each lane's sum is computed at psum_bw+1 bits, then clamped to [-2^(psum_bw-1), 2^(psum_bw-1)-1].
- **Forwarding:** if stage 2 holds a pending sum for address A, any read or accumulate accepted on the same cycle for A must use that pending sum, not the stale memory contents. Back-to-back accumulates to one address therefore sum correctly at full throughput.
- **Write/commit collision:** if a write to A is accepted on the same edge that stage 2 commits to A, the write wins.
- **Clear:** accepting mode 11 moves the FSM from IDLE to CLEAR.
  - One entry per cycle is zeroed, addresses 0 through depth-1, after any pending stage-2 commit has landed.
  - The FSM then returns to IDLE.
  - `busy` equals (state == CLEAR).
- **Reset:**
  - Returns to IDLE and aborts any clear sweep.
  - Drops any pending stage-2 commit.
  - `out_valid` = 0, `out_data` = 0, `busy` = 0.
  - Memory contents are not reset.

## Timing
- Write: the data is readable by a read accepted on the next cycle.
- Read: `out_valid` rises on the edge after the accept (latency 1). Throughput is 1 per cycle while `out_ready` = 1.
- Accumulate: the result is in memory 2 edges after the accept and is visible via forwarding 1 cycle after the accept. Throughput is 1 per cycle.
- Clear: `busy` rises on the edge after the accept and stays high for exactly `depth` cycles. `in_ready` returns to 1 on the first cycle after `busy` falls.
- Reset asserted mid-clear: `busy` is 0 on the edge after reset. Entries not yet reached by the sweep keep their old values.

## Test plan
- **Reset:** hold `reset` for 2 cycles → `out_valid` = 0, `out_data` = 0, `busy` = 0, `in_ready` = 0 during reset and 1 after it.
- **Write/read with backpressure:** write addr 5 with all lanes 0x0010, then read addr 5 with `out_ready` = 0 → `out_valid` = 1 one cycle later with lanes 0x0010. `out_data` holds while `out_ready` stays 0, and a second read sees `in_ready` = 0. Raise `out_ready` → one transfer, then `out_valid` = 0.
- **Forwarding:** write addr 7 = 0, then three accumulates of lane value 3 on consecutive cycles, then read addr 7 → all lanes 9. Also: accumulate 3 to addr 7 immediately followed by a write of 1 to addr 7 → a later read returns 1.
- **Saturation:** write 0x7FF0 and accumulate 0x0020 → 0x7FFF. Write 0x8010 and accumulate 0xFFE0 → 0x8000. Write 0x0005 and accumulate 0xFFFD → 0x0002.
- **ReLU:** lane0 = 0xFFFB, lane1 = 0x0005. Read with `relu_en` = 1 → 0x0000 and 0x0005. Read with `relu_en` = 0 → 0xFFFB and 0x0005.
- **Clear (`depth` = 16):** fill all entries with 0x1234, then issue a clear.
  - `busy` is high for exactly 16 cycles; every read afterwards returns 0.
  - Repeat the fill and clear, asserting `reset` on the 4th busy cycle. `busy` is 0 on the next edge, entries 0 through 2 read 0, and entry 15 reads 0x1234.
